iter_muldiv_unit: RTL and testbench

Multi-cycle unsigned multiply/divide execution unit. It sits directly downstream of the register file, consuming its two read-port values (rd_data1/rd_data2) as operands. When finished, it produces the write-back triple (wr_reg, wr_data, reg_write) that feeds the register file write port. It uses a shift-add multiplier and a restoring divider, one bit per clock.

---
 rtl/iter_muldiv_pkg.sv | 23 ++
 rtl/iter_muldiv_unit_step.sv | 41 ++++
 rtl/iter_muldiv_unit.sv | 158 +++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds the FSM state encoding, the operation codes and the default sizes.
package iter_muldiv_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULHU = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_REMU  = 2'd3;

  function automatic logic op_is_div(input logic [1:0] o);
    return (o == OP_DIVU) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/iter_muldiv_unit_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// For multiply the accumulator pair is the product; for divide it is {remainder, quotient}.
module muldiv_step
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_hi_next,
  output logic [WIDTH-1:0] acc_lo_next
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;

  // The carry out of the add becomes the top bit of the product after the shift.
  assign w_sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, operand}) : {1'b0, acc_hi};

  assign w_shifted = {acc_hi, acc_lo[WIDTH-1]};
  assign w_borrow  = (w_shifted < {1'b0, operand});
  // When there is no borrow the true difference is below the divisor, so WIDTH bits suffice.
  assign w_diff    = w_shifted[WIDTH-1:0] - operand;

  always_comb begin
    acc_hi_next = '0;
    acc_lo_next = '0;
    if (is_div) begin
      acc_hi_next = w_borrow ? w_shifted[WIDTH-1:0] : w_diff;
      acc_lo_next = {acc_lo[WIDTH-2:0], ~w_borrow};
    end else begin
      acc_hi_next = w_sum[WIDTH:1];
      acc_lo_next = {w_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_muldiv_unit.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU unit producing a register-file write-back.
// One datapath bit per clock; the result is presented for one cycle on done/reg_write.
module iter_muldiv_unit
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      operand_a,
  input  logic [WIDTH-1:0]      operand_b,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] wr_reg,
  output logic [WIDTH-1:0]      wr_data,
  output state_t                dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_op;
  logic [WIDTH-1:0]      r_operand;
  logic [WIDTH-1:0]      r_acc_hi;
  logic [WIDTH-1:0]      r_acc_lo;
  logic [REG_ADDR_W-1:0] r_dest;
  logic                  r_busy;
  logic                  r_done;
  logic [REG_ADDR_W-1:0] r_wr_reg;
  logic [WIDTH-1:0]      r_wr_data;

  logic                  w_accept;
  logic                  w_new_is_div;
  logic                  w_div_zero;
  logic                  w_run_is_div;
  logic [WIDTH-1:0]      w_hi_next;
  logic [WIDTH-1:0]      w_lo_next;
  logic [WIDTH-1:0]      w_result;

  // Handshake: start is taken only at an edge where the unit is IDLE and flush is low;
  // busy covers the whole operation including the cycle the result is presented, and
  // the result is valid exactly while done (= reg_write) is high.
  assign w_accept     = (r_state == ST_IDLE) && start && !flush;
  assign w_new_is_div = op_is_div(op);
  assign w_div_zero   = w_new_is_div && (operand_b == '0);
  assign w_run_is_div = op_is_div(r_op);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div      (w_run_is_div),
    .acc_hi      (r_acc_hi),
    .acc_lo      (r_acc_lo),
    .operand     (r_operand),
    .acc_hi_next (w_hi_next),
    .acc_lo_next (w_lo_next)
  );

  always_comb begin
    w_result = '0;
    case (r_op)
      OP_MUL:   w_result = r_acc_lo;
      OP_MULHU: w_result = r_acc_hi;
      OP_DIVU:  w_result = r_acc_lo;
      default:  w_result = r_acc_hi;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= OP_MUL;
      r_operand <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_dest    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
    end else begin
      r_done    <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (w_accept) begin
            r_op   <= op;
            r_dest <= dest_reg;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_div_zero) begin
              // Preload the divide-by-zero answers so DONE selects them like any result.
              r_operand <= operand_b;
              r_acc_hi  <= operand_a;
              r_acc_lo  <= '1;
              r_state   <= ST_DONE;
            end else if (w_new_is_div) begin
              r_operand <= operand_b;
              r_acc_hi  <= '0;
              r_acc_lo  <= operand_a;
              r_state   <= ST_RUN;
            end else begin
              r_operand <= operand_a;
              r_acc_hi  <= '0;
              r_acc_lo  <= operand_b;
              r_state   <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_acc_hi <= w_hi_next;
            r_acc_lo <= w_lo_next;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_STEP) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          if (flush) begin
            r_busy <= 1'b0;
          end else begin
            r_busy    <= 1'b1;
            r_done    <= 1'b1;
            r_wr_reg  <= r_dest;
            r_wr_data <= w_result;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign reg_write = r_done;
  assign wr_reg    = r_wr_reg;
  assign wr_data   = r_wr_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed self-checking bench for iter_muldiv_unit (WIDTH=32, 16 registers).
// Inputs change and outputs are sampled on the falling edge.
module tb_iter_muldiv_unit;
  import iter_muldiv_pkg::*;

  localparam int W  = 32;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic [AW-1:0] dest_reg;
  logic          flush;
  logic          busy;
  logic          done;
  logic          reg_write;
  logic [AW-1:0] wr_reg;
  logic [W-1:0]  wr_data;
  state_t        dbg_state;

  int n_checks;
  int n_fail;
  logic [W-1:0] exp_q[$];

  iter_muldiv_unit #(.WIDTH(W), .REG_ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .dest_reg  (dest_reg),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .reg_write (reg_write),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: issue one op from IDLE, scramble inputs after the accepting edge, wait for done.
  // lat counts rising edges after the accepting edge until done is seen.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [AW-1:0] d, output int lat, output logic [W-1:0] data,
                        output logic [AW-1:0] rg, output logic rw);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = d;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    op        = 2'($urandom_range(0, 3));
    operand_a = $urandom;
    operand_b = $urandom;
    dest_reg  = AW'($urandom_range(0, 15));
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    data = wr_data; rg = wr_reg; rw = reg_write;
  endtask

  task automatic test_reset();
    int seen, lat;
    logic [W-1:0] data;
    logic [AW-1:0] rg;
    logic rw;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MUL;
    operand_a = '0; operand_b = '0; dest_reg = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0 || reg_write !== 1'b0) begin n_fail++; $display("FAIL reset_done: got done=%b rw=%b expected 0/0", done, reg_write); end
    n_checks++; if (wr_data !== '0 || wr_reg !== '0) begin n_fail++; $display("FAIL reset_wr: got data=%h reg=%h expected 0/0", wr_data, wr_reg); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    rst = 1'b0;

    // Reset in the middle of MUL 7*6.
    @(negedge clk);
    start = 1'b1; op = OP_MUL; operand_a = 32'd7; operand_b = 32'd6; dest_reg = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_run_busy: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || reg_write !== 1'b0 || wr_data !== '0) begin
      n_fail++; $display("FAIL async_reset: got busy=%b done=%b rw=%b data=%h expected 0", busy, done, reg_write, wr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || reg_write === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL reset_no_done: got %0d pulses expected 0", seen); end

    run_op(OP_MUL, 32'd7, 32'd6, 4'd3, lat, data, rg, rw);
    n_checks++; if (data !== 32'd42) begin n_fail++; $display("FAIL post_reset_mul: got %h expected %h", data, 32'd42); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL post_reset_lat: got %0d expected 33", lat); end
  endtask

  task automatic test_mul();
    int lat;
    logic [W-1:0] data;
    logic [AW-1:0] rg;
    logic rw;
    run_op(OP_MUL, 32'h0000_1234, 32'h0000_0010, 4'd5, lat, data, rg, rw);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    n_checks++; if (data !== 32'h0001_2340) begin n_fail++; $display("FAIL mul_data: got %h expected 00012340", data); end
    n_checks++; if (rg !== 4'd5 || rw !== 1'b1) begin n_fail++; $display("FAIL mul_wb: got reg=%0d rw=%b expected 5/1", rg, rw); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy_in_done: got %b expected 1", busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || reg_write !== 1'b0) begin n_fail++; $display("FAIL mul_one_pulse: got done=%b rw=%b expected 0/0", done, reg_write); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_idle_after: got busy=%b expected 0", busy); end

    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, lat, data, rg, rw);
    n_checks++; if (data !== 32'hFFFF_FFFE || rg !== 4'd9) begin n_fail++; $display("FAIL mulhu_data: got %h reg=%0d expected fffffffe reg=9", data, rg); end
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, lat, data, rg, rw);
    n_checks++; if (data !== 32'h0000_0001) begin n_fail++; $display("FAIL mul_low_max: got %h expected 00000001", data); end
    run_op(OP_MULHU, 32'h8000_0000, 32'h0000_0004, 4'd1, lat, data, rg, rw);
    n_checks++; if (data !== 32'h0000_0002) begin n_fail++; $display("FAIL mulhu_carry: got %h expected 00000002", data); end
  endtask

  task automatic test_div();
    int lat;
    logic [W-1:0] data;
    logic [AW-1:0] rg;
    logic rw;
    run_op(OP_DIVU, 32'd100, 32'd7, 4'd2, lat, data, rg, rw);
    n_checks++; if (data !== 32'd14 || lat !== 33) begin n_fail++; $display("FAIL divu_100_7: got %0d lat=%0d expected 14 lat=33", data, lat); end
    run_op(OP_REMU, 32'd100, 32'd7, 4'd4, lat, data, rg, rw);
    n_checks++; if (data !== 32'd2 || rg !== 4'd4) begin n_fail++; $display("FAIL remu_100_7: got %0d reg=%0d expected 2 reg=4", data, rg); end
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 4'd6, lat, data, rg, rw);
    n_checks++; if (data !== 32'h0FFF_FFFF) begin n_fail++; $display("FAIL divu_max: got %h expected 0fffffff", data); end
    run_op(OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 4'd6, lat, data, rg, rw);
    n_checks++; if (data !== 32'h0000_000F) begin n_fail++; $display("FAIL remu_max: got %h expected 0000000f", data); end
    run_op(OP_DIVU, 32'h0000_0055, 32'h0, 4'd7, lat, data, rg, rw);
    n_checks++; if (data !== 32'hFFFF_FFFF || lat !== 1) begin n_fail++; $display("FAIL divu_by_zero: got %h lat=%0d expected ffffffff lat=1", data, lat); end
    n_checks++; if (rg !== 4'd7 || rw !== 1'b1) begin n_fail++; $display("FAIL divu_zero_wb: got reg=%0d rw=%b expected 7/1", rg, rw); end
    run_op(OP_REMU, 32'h0000_0055, 32'h0, 4'd8, lat, data, rg, rw);
    n_checks++; if (data !== 32'h0000_0055 || lat !== 1) begin n_fail++; $display("FAIL remu_by_zero: got %h lat=%0d expected 00000055 lat=1", data, lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] exp_v;
    @(negedge clk);
    start = 1'b1; op = OP_MUL; operand_a = 32'd3; operand_b = 32'd5; dest_reg = 4'd1;
    exp_q.push_back(32'd15);
    @(posedge clk);
    @(negedge clk);
    // start stays high; the next operands must not disturb the running op
    op = OP_MUL; operand_a = 32'd9; operand_b = 32'd4; dest_reg = 4'd2;
    exp_q.push_back(32'd36);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    exp_v = exp_q.pop_front();
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_first_lat: got %0d expected 33", lat); end
    n_checks++; if (wr_data !== exp_v || wr_reg !== 4'd1) begin n_fail++; $display("FAIL b2b_first: got %0d reg=%0d expected %0d reg=1", wr_data, wr_reg, exp_v); end
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_second_accept: got busy=%b done=%b expected 1/0", busy, done); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      // A divide-by-zero start pulse during RUN would finish at once if it were taken.
      if (lat == 10) begin start = 1'b1; op = OP_DIVU; operand_b = '0; end
      else start = 1'b0;
    end
    exp_v = exp_q.pop_front();
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 33", lat); end
    n_checks++; if (wr_data !== exp_v || wr_reg !== 4'd2) begin n_fail++; $display("FAIL b2b_second: got %0d reg=%0d expected %0d reg=2", wr_data, wr_reg, exp_v); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_queue: got %0d left expected 0", exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    int seen, lat;
    logic [W-1:0] data;
    logic [AW-1:0] rg;
    logic rw;
    @(negedge clk);
    start = 1'b1; op = OP_MUL; operand_a = 32'd11; operand_b = 32'd13; dest_reg = 4'd12;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL flush_run: got busy=%b done=%b state=%0d expected 0/0/%0d", busy, done, dbg_state, ST_IDLE);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || reg_write === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", seen); end

    run_op(OP_MUL, 32'd6, 32'd7, 4'd14, lat, data, rg, rw);
    flush = 1'b1;
    #1;
    n_checks++; if (done !== 1'b1 || reg_write !== 1'b1 || wr_data !== 32'd42 || wr_reg !== 4'd14) begin
      n_fail++; $display("FAIL flush_in_done: got done=%b rw=%b data=%0d reg=%0d expected 1/1/42/14", done, reg_write, wr_data, wr_reg);
    end
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_after_done: got done=%b busy=%b expected 0/0", done, busy); end

    start = 1'b1; flush = 1'b1; op = OP_MUL; operand_a = 32'd1; operand_b = 32'd1;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL start_with_flush: got busy=%b state=%0d expected 0/%0d", busy, dbg_state, ST_IDLE); end
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
